score_tracker: RTL and testbench
================================

# score_tracker

Game-progress bookkeeping stage sitting directly upstream of the end screen. Counts successful landings as a 3-digit BCD score, detects game over, and maintains a best score with a new-record flag. Generates the one-second tick that drives end-screen blinking. All outputs are registered and feed the end-screen text overlays and the in-game score display.

## Interface
Parameters:
- `TICK_DIV`, default 65_000_000: clock cycles per `one_sec_tick` period (65 MHz pixel clock). Legal range is ≥2.

Ports:
- `clk`  in  1  system/pixel clock; all logic on its rising edge
- `rst`  in  1  synchronous reset, active-low (asserted when 0)
- `game_start`  in  1  one-cycle pulse; starts a new round
- `jump_ok`  in  1  one-cycle pulse; player landed successfully
- `jump_fail`  in  1  one-cycle pulse; player missed, round ends
- `score`  out  12  current score, BCD: [11:8] hundreds, [7:4] tens, [3:0] units
- `best_score`  out  12  highest final score since reset, BCD
- `new_record`  out  1  high in ENDED when the last round strictly beat the previous best
- `game_over`  out  1  high while in ENDED
- `one_sec_tick`  out  1  one-cycle pulse every `TICK_DIV` cycles

## Operation
- FSM states: IDLE (reset state), PLAYING, ENDED.
- IDLE:
  - `game_start` → PLAYING; `score` ← 0, `new_record` ← 0.
  - `jump_ok` and `jump_fail` are ignored.
- PLAYING:
  - `jump_fail` → ENDED. The final score is compared with `best_score` as an unsigned 12-bit value; BCD ordering equals binary ordering.
    - If final score > best: `best_score` ← score and `new_record` ← 1.
    - Otherwise both are unchanged and `new_record` ← 0.
  - `jump_ok` without `jump_fail`: BCD increment of `score`.
    - Units 9 → 0 carries into tens; tens 9 → 0 carries into hundreds.
    - 999 saturates: `score` holds 999 and no wrap occurs.
  - `jump_ok` and `jump_fail` in the same cycle: fail wins. No increment; the pre-increment score is final.
  - `game_start` is ignored.
- ENDED:
  - `score`, `best_score`, `new_record` are frozen.
  - `game_start` → PLAYING; `score` ← 0, `new_record` ← 0. `best_score` is retained.
  - `jump_ok` and `jump_fail` are ignored.
- Only `rst` clears `best_score`.
- `game_over` = (state == ENDED), decoded from the registered state; no input feed-through.
- Tick generator:
  - Counter `tick_cnt` runs 0 … `TICK_DIV`−1 and wraps, free-running in every state.
  - `one_sec_tick` is registered, high for exactly the cycle following `tick_cnt == TICK_DIV-1`.
  - On the PLAYING→ENDED transition, `tick_cnt` ← 0 and `one_sec_tick` ← 0. This makes the first end-screen tick occur exactly `TICK_DIV` cycles after `game_over` rises.
- Score digits never leave 0–9. Counter width is ceil(log2(`TICK_DIV`)).

## Timing
- Reset (`rst`=0 at a clock edge) forces:
  - state = IDLE, `score` = 0, `best_score` = 0
  - `new_record` = 0, `game_over` = 0, `one_sec_tick` = 0, `tick_cnt` = 0
- Reset applied mid-round or in ENDED takes effect at that edge and discards the best score.
- Latency, all measured from the input-pulse edge:
  - `jump_ok` → `score` updated 1 cycle later.
  - `jump_fail` → `game_over`, `new_record`, `best_score` valid 1 cycle later, all on the same edge.
  - `game_start` → `score` = 0 and `game_over` = 0 one cycle later.
- Inputs are sampled every cycle; no handshake. Held-high inputs act as one event per cycle. Upstream guarantees single-cycle pulses.
- Tick period is exactly `TICK_DIV` cycles and its pulse width is 1 cycle.

## Test plan
- Reset then `game_start`, 12 × `jump_ok`, then `jump_fail` → `score` = 0x012, `best_score` = 0x012, `new_record` = 1, `game_over` = 1 one cycle after `jump_fail`.
- Carry and saturation: starting from score 0x099, one `jump_ok` → 0x100; continue to 0x999, one more `jump_ok` → still 0x999. No digit ever exceeds 9.
- Second round ending at 0x005 with best 0x012 → `best_score` = 0x012, `new_record` = 0. A third round ending at 0x012 (equal) → `new_record` = 0.
- Simultaneous `jump_ok` and `jump_fail` at score 0x007 → final score 0x007, ENDED. A `jump_ok` in ENDED or IDLE leaves `score` unchanged; `game_start` in PLAYING is ignored.
- With `TICK_DIV`=10: ticks are exactly 10 cycles apart. After `jump_fail`, the first tick arrives 10 cycles after `game_over` rises, regardless of prior phase.
- `rst` low mid-round at score 0x034 with best 0x050 → every output is 0 on the next edge, and state is IDLE.

Source files
------------

// File: rtl/score_tracker.sv
`default_nettype none
// ============================================================================
//  Module   : score_tracker
//  Purpose  : Round FSM with a saturating 3-digit BCD score, best-score and
//             new-record bookkeeping, and a free-running one-second tick
//             that restarts when a round ends.
//  Revision : 1.0  initial release
// ============================================================================
module score_tracker #(
  parameter int TICK_DIV = 65_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        game_start,
  input  logic        jump_ok,
  input  logic        jump_fail,
  output logic [11:0] score,
  output logic [11:0] best_score,
  output logic        new_record,
  output logic        game_over,
  output logic        one_sec_tick
);

  localparam int            CW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PLAYING = 2'd1,
    S_ENDED   = 2'd2
  } state_t;

  state_t        state_q;
  logic [11:0]   score_q;
  logic [11:0]   score_d;
  logic [11:0]   best_q;
  logic          new_record_q;
  logic [CW-1:0] tick_cnt_q;
  logic          tick_q;
  logic          end_round_w;

  // A miss while playing closes the round; it also re-phases the tick.
  assign end_round_w = (state_q == S_PLAYING) && jump_fail;

  // BCD increment of the score, holding at 999 instead of wrapping.
  always_comb begin
    score_d = score_q;
    if (score_q != 12'h999) begin
      if (score_q[3:0] != 4'd9) begin
        score_d[3:0] = score_q[3:0] + 4'd1;
      end else begin
        score_d[3:0] = 4'd0;
        if (score_q[7:4] != 4'd9) begin
          score_d[7:4] = score_q[7:4] + 4'd1;
        end else begin
          score_d[7:4]  = 4'd0;
          score_d[11:8] = score_q[11:8] + 4'd1;
        end
      end
    end
  end

  // Round FSM with the score, best score and record flag as registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      score_q      <= 12'h000;
      best_q       <= 12'h000;
      new_record_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_ENDED: begin
          if (game_start) begin
            state_q      <= S_PLAYING;
            score_q      <= 12'h000;
            new_record_q <= 1'b0;
          end
        end
        S_PLAYING: begin
          if (jump_fail) begin
            // BCD digit order matches binary magnitude order, so a plain
            // unsigned compare decides the record.
            state_q <= S_ENDED;
            if (score_q > best_q) begin
              best_q       <= score_q;
              new_record_q <= 1'b1;
            end else begin
              new_record_q <= 1'b0;
            end
          end else if (jump_ok) begin
            score_q <= score_d;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Free-running tick divider, restarted at round end so the first
  // end-screen tick lands exactly TICK_DIV cycles after game_over rises.
  always_ff @(posedge clk) begin
    if (!rst) begin
      tick_cnt_q <= '0;
      tick_q     <= 1'b0;
    end else if (end_round_w) begin
      tick_cnt_q <= '0;
      tick_q     <= 1'b0;
    end else if (tick_cnt_q == CNT_MAX) begin
      tick_cnt_q <= '0;
      tick_q     <= 1'b1;
    end else begin
      tick_cnt_q <= tick_cnt_q + CW'(1);
      tick_q     <= 1'b0;
    end
  end

  assign score        = score_q;
  assign best_score   = best_q;
  assign new_record   = new_record_q;
  assign game_over    = (state_q == S_ENDED);
  assign one_sec_tick = tick_q;

endmodule
`default_nettype wire

// File: tb/tb_score_tracker.sv
`default_nettype none
// ============================================================================
//  Module   : tb_score_tracker
//  Purpose  : Self-checking bench for score_tracker (TICK_DIV = 10).
//  Revision : 1.0  initial release
// ============================================================================
module tb_score_tracker;

  localparam int TD = 10;

  logic        clk;
  logic        rst;
  logic        game_start;
  logic        jump_ok;
  logic        jump_fail;
  logic [11:0] score;
  logic [11:0] best_score;
  logic        new_record;
  logic        game_over;
  logic        one_sec_tick;

  score_tracker #(.TICK_DIV(TD)) dut (
    .clk          (clk),
    .rst          (rst),
    .game_start   (game_start),
    .jump_ok      (jump_ok),
    .jump_fail    (jump_fail),
    .score        (score),
    .best_score   (best_score),
    .new_record   (new_record),
    .game_over    (game_over),
    .one_sec_tick (one_sec_tick)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: round phase, decimal score, decimal best, and the
  // number of edges since the last tick anchor (reset or round end).
  int m_phase = 0;   // 0 idle, 1 playing, 2 ended
  int m_sc    = 0;
  int m_best  = 0;
  int m_nr    = 0;
  int m_k     = 0;

  function automatic logic [11:0] to_bcd(input int n);
    return {4'(n / 100), 4'((n / 10) % 10), 4'(n % 10)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input logic r, input logic g, input logic o, input logic f);
    if (!r) begin
      m_phase = 0; m_sc = 0; m_best = 0; m_nr = 0; m_k = 0;
    end else begin
      m_k++;
      if (m_phase == 1) begin
        if (f) begin
          m_phase = 2;
          m_k     = 0;
          if (m_sc > m_best) begin
            m_best = m_sc;
            m_nr   = 1;
          end else begin
            m_nr = 0;
          end
        end else if (o) begin
          m_sc = (m_sc < 999) ? m_sc + 1 : 999;
        end
      end else if (g) begin
        m_phase = 1; m_sc = 0; m_nr = 0;
      end
    end
  endtask

  // One clock: drive inputs, advance the model, compare every output.
  task automatic step(input logic r, input logic g, input logic o, input logic f);
    rst = r; game_start = g; jump_ok = o; jump_fail = f;
    @(posedge clk);
    model_edge(r, g, o, f);
    #1;
    chk("score",        32'(score),        32'(to_bcd(m_sc)));
    chk("best_score",   32'(best_score),   32'(to_bcd(m_best)));
    chk("new_record",   32'(new_record),   32'(m_nr));
    chk("game_over",    32'(game_over),    32'(m_phase == 2));
    chk("one_sec_tick", 32'(one_sec_tick), 32'((m_k > 0) && (m_k % TD == 0)));
  endtask

  typedef struct {
    logic        r, g, o, f;
    logic [11:0] sc, best;
    logic        nr, go;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic r, input logic g, input logic o, input logic f,
                              input logic [11:0] sc, input logic [11:0] best,
                              input logic nr, input logic go);
    vec_t v;
    v.r = r; v.g = g; v.o = o; v.f = f;
    v.sc = sc; v.best = best; v.nr = nr; v.go = go;
    return v;
  endfunction

  int t1, t2, lat, sat_bad;

  initial begin
    rst = 1'b0; game_start = 1'b0; jump_ok = 1'b0; jump_fail = 1'b0;

    // ---- table of directed vectors ----
    tbl.push_back(mk(0, 0, 0, 0, 12'h000, 12'h000, 0, 0));          // reset
    tbl.push_back(mk(1, 0, 1, 0, 12'h000, 12'h000, 0, 0));          // ok in IDLE ignored
    tbl.push_back(mk(1, 1, 0, 0, 12'h000, 12'h000, 0, 0));          // start
    for (int i = 1; i <= 12; i++)
      tbl.push_back(mk(1, 0, 1, 0, to_bcd(i), 12'h000, 0, 0));
    tbl.push_back(mk(1, 0, 0, 1, 12'h012, 12'h012, 1, 1));          // first round ends
    tbl.push_back(mk(1, 0, 1, 0, 12'h012, 12'h012, 1, 1));          // ok in ENDED ignored
    tbl.push_back(mk(1, 0, 0, 1, 12'h012, 12'h012, 1, 1));          // fail in ENDED ignored
    tbl.push_back(mk(1, 1, 0, 0, 12'h000, 12'h012, 0, 0));          // second round
    for (int i = 1; i <= 5; i++)
      tbl.push_back(mk(1, 0, 1, 0, to_bcd(i), 12'h012, 0, 0));
    tbl.push_back(mk(1, 0, 0, 1, 12'h005, 12'h012, 0, 1));          // lower, no record
    tbl.push_back(mk(1, 1, 0, 0, 12'h000, 12'h012, 0, 0));          // third round
    for (int i = 1; i <= 12; i++)
      tbl.push_back(mk(1, 0, 1, 0, to_bcd(i), 12'h012, 0, 0));
    tbl.push_back(mk(1, 0, 0, 1, 12'h012, 12'h012, 0, 1));          // equal, no record
    tbl.push_back(mk(1, 1, 0, 0, 12'h000, 12'h012, 0, 0));          // fourth round
    for (int i = 1; i <= 7; i++)
      tbl.push_back(mk(1, 0, 1, 0, to_bcd(i), 12'h012, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 12'h007, 12'h012, 0, 0));          // start while playing ignored
    tbl.push_back(mk(1, 0, 1, 1, 12'h007, 12'h012, 0, 1));          // ok+fail: fail wins

    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].g, tbl[i].o, tbl[i].f);
      chk("tbl_score",      32'(score),      32'(tbl[i].sc));
      chk("tbl_best",       32'(best_score), 32'(tbl[i].best));
      chk("tbl_new_record", 32'(new_record), 32'(tbl[i].nr));
      chk("tbl_game_over",  32'(game_over),  32'(tbl[i].go));
    end

    // ---- carry and saturation ----
    step(1, 1, 0, 0);
    for (int i = 0; i < 99; i++) step(1, 0, 1, 0);
    chk("carry_099", 32'(score), 32'h099);
    step(1, 0, 1, 0);
    chk("carry_100", 32'(score), 32'h100);
    sat_bad = 0;
    for (int i = 0; i < 899; i++) begin
      step(1, 0, 1, 0);
      if (score[3:0] > 4'd9 || score[7:4] > 4'd9 || score[11:8] > 4'd9) sat_bad++;
    end
    chk("digits_le_9", 32'(sat_bad), 32'd0);
    chk("reach_999", 32'(score), 32'h999);
    step(1, 0, 1, 0);
    chk("sat_999", 32'(score), 32'h999);
    step(1, 0, 0, 1);
    chk("sat_best", 32'(best_score), 32'h999);

    // ---- tick period and restart on round end ----
    t1 = -1; t2 = -1;
    for (int i = 0; i < 3 * TD && t2 < 0; i++) begin
      step(1, 0, 0, 0);
      if (one_sec_tick) begin
        if (t1 < 0) t1 = i; else t2 = i;
      end
    end
    chk("tick_seen", 32'(t2 >= 0), 32'd1);
    chk("tick_period", 32'(t2 - t1), 32'(TD));
    for (int rep = 0; rep < 4; rep++) begin
      step(1, 1, 0, 0);
      for (int i = 0; i < int'($urandom_range(0, 2 * TD)); i++) step(1, 0, 1, 0);
      step(1, 0, 0, 1);
      chk("go_rise", 32'(game_over), 32'd1);
      lat = -1;
      for (int i = 1; i <= 3 * TD && lat < 0; i++) begin
        step(1, 0, 0, 0);
        if (one_sec_tick) lat = i;
      end
      chk("tick_after_end", 32'(lat), 32'(TD));
    end

    // ---- reset mid-round ----
    step(0, 0, 0, 0);
    step(1, 1, 0, 0);
    for (int i = 0; i < 50; i++) step(1, 0, 1, 0);
    step(1, 0, 0, 1);
    chk("best_050", 32'(best_score), 32'h050);
    step(1, 1, 0, 0);
    for (int i = 0; i < 34; i++) step(1, 0, 1, 0);
    chk("pre_rst_034", 32'(score), 32'h034);
    step(0, 0, 1, 0);
    chk("rst_outputs", 32'({score, best_score, new_record, game_over, one_sec_tick}), 32'd0);
    step(1, 0, 1, 0);
    chk("idle_after_rst", 32'(score), 32'h000);

    // ---- randomized stimulus against the model ----
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 499) != 0),
           ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 39) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
